// File: rtl/utap_pkg.sv
// Shared constants and state type for the debug-tap frame scheduler.
package utap_pkg;

    localparam logic [2:0] UTAP_NONE = 3'h0;
    localparam logic [2:0] UTAP_PC   = 3'h1;

    localparam int UTAP_FRAME_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE,
        SELECT,
        SHIFT,
        DONE
    } utap_state_e;

endpackage

// File: rtl/utap_rr_arb.sv
// Requester arbiter: one-hot grant from a request vector. Round-robin when
// UTAP_SCHED_RR_EN is defined, fixed lowest-index priority otherwise.
module utap_rr_arb #(
    parameter int N_REQ = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             advance,
    output logic [N_REQ-1:0] grant
);

`ifdef UTAP_SCHED_RR_EN
    logic [1:0] ptr_q;
    logic [1:0] ptr_d;
    logic       found;
    int         win;

    // The pointer holds the first index to search, so a winner moves to the back.
    always_comb begin
        grant = '0;
        found = 1'b0;
        win   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!found && req[i] && ((int'(ptr_q) + k) % N_REQ == i)) begin
                    grant[i] = 1'b1;
                    win      = i;
                    found    = 1'b1;
                end
            end
        end
        ptr_d = ptr_q;
        if (advance && found) begin
            ptr_d = (win == N_REQ - 1) ? 2'd0 : 2'(win + 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 2'd0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    logic unused_arb;
    logic found;

    assign unused_arb = clk ^ rst_n ^ advance;

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req[i]) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/utap_sched.sv
// Debug-tap frame scheduler: grants one requester, selects its tap domain,
// shifts one frame MSB-first and returns the captured frame (UTAP_SCHED_RR_EN).
module utap_sched
    import utap_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int FRAME_W = UTAP_FRAME_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [3*N_REQ-1:0]       req_sel,
    input  logic [FRAME_W*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     rsp_valid,
    output logic [1:0]               rsp_id,
    output logic [FRAME_W-1:0]       rsp_data,
    output logic                     rsp_err,
    output logic [2:0]               tap_sel,
    output logic                     tap_si,
    input  logic                     tap_so,
    output logic                     busy
);

    localparam int CNT_W = $clog2(FRAME_W + 1);

    utap_state_e        state_q, state_d;
    logic [2:0]         sel_q, sel_d;
    logic [FRAME_W-1:0] tx_q, tx_d;
    logic [FRAME_W-1:0] rx_q, rx_d;
    logic [1:0]         idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         rsp_id_q, rsp_id_d;
    logic [FRAME_W-1:0] rsp_data_q, rsp_data_d;
    logic               rsp_err_q, rsp_err_d;

    logic [N_REQ-1:0]   grant;
    logic               advance;
    logic [1:0]         g_idx;
    logic [2:0]         g_sel;
    logic [FRAME_W-1:0] g_data;

    utap_rr_arb #(
        .N_REQ(N_REQ)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid),
        .advance (advance),
        .grant   (grant)
    );

    always_comb begin
        g_idx  = 2'd0;
        g_sel  = UTAP_NONE;
        g_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                g_idx  = 2'(i);
                g_sel  = req_sel[3*i +: 3];
                g_data = req_data[FRAME_W*i +: FRAME_W];
            end
        end
    end

    // Response fields are loaded only on entry to DONE so they hold between frames.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        rsp_id_d   = rsp_id_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        req_ready  = '0;
        advance    = 1'b0;
        rsp_valid  = 1'b0;
        tap_sel    = UTAP_NONE;
        tap_si     = 1'b0;

        case (state_q)
            IDLE: begin
                if (rst_n && (|req_valid)) begin
                    req_ready = grant;
                    advance   = 1'b1;
                    sel_d     = g_sel;
                    tx_d      = g_data;
                    rx_d      = '0;
                    idx_d     = g_idx;
                    cnt_d     = '0;
                    if (g_sel == UTAP_NONE) begin
                        state_d    = DONE;
                        rsp_id_d   = g_idx;
                        rsp_data_d = '0;
                        rsp_err_d  = 1'b1;
                    end else begin
                        state_d = SELECT;
                    end
                end
            end
            SELECT: begin
                tap_sel = sel_q;
                state_d = SHIFT;
            end
            SHIFT: begin
                tap_sel = sel_q;
                tap_si  = tx_q[FRAME_W-1];
                tx_d    = tx_q << 1;
                rx_d    = {rx_q[FRAME_W-2:0], tap_so};
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(FRAME_W - 1)) begin
                    state_d    = DONE;
                    cnt_d      = '0;
                    rsp_id_d   = idx_q;
                    rsp_data_d = rx_d;
                    rsp_err_d  = 1'b0;
                end
            end
            DONE: begin
                rsp_valid = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sel_q      <= UTAP_NONE;
            tx_q       <= '0;
            rx_q       <= '0;
            idx_q      <= 2'd0;
            cnt_q      <= '0;
            rsp_id_q   <= 2'd0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            rsp_id_q   <= rsp_id_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign rsp_id   = rsp_id_q;
    assign rsp_data = rsp_data_q;
    assign rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_utap_sched.sv
// Bench for utap_sched: directed scenarios and random traffic compared each
// cycle against a transaction-level timeline model of the scheduler.
module tb_utap_sched;
    import utap_pkg::*;

    localparam int N_REQ   = 2;
    localparam int FRAME_W = 16;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [N_REQ-1:0]         req_valid = '0;
    logic [3*N_REQ-1:0]       req_sel = '0;
    logic [FRAME_W*N_REQ-1:0] req_data = '0;
    logic [N_REQ-1:0]         req_ready;
    logic                     rsp_valid;
    logic [1:0]               rsp_id;
    logic [FRAME_W-1:0]       rsp_data;
    logic                     rsp_err;
    logic [2:0]               tap_sel;
    logic                     tap_si;
    logic                     tap_so = 1'b0;
    logic                     busy;

    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    logic tap_random = 1'b0;
    logic [N_REQ-1:0] acc;

    utap_sched #(
        .N_REQ   (N_REQ),
        .FRAME_W (FRAME_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_sel   (req_sel),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .tap_sel   (tap_sel),
        .tap_si    (tap_si),
        .tap_so    (tap_so),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Tap stand-in: echoes tap_si one cycle later, or returns noise.
    always @(posedge clk) begin
        cyc    <= cyc + 1;
        tap_so <= tap_random ? 1'($urandom) : tap_si;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input int i, input logic v, input logic [2:0] s, input logic [FRAME_W-1:0] d);
        req_valid[i]                  = v;
        req_sel[3*i +: 3]             = s;
        req_data[FRAME_W*i +: FRAME_W] = d;
    endtask

    function automatic int pickWinner(input logic [N_REQ-1:0] v, input int ptr);
`ifdef UTAP_SCHED_RR_EN
        for (int k = 0; k < N_REQ; k++) if (v[(ptr + k) % N_REQ]) return (ptr + k) % N_REQ;
`else
        for (int k = 0; k < N_REQ; k++) if (v[k]) return k;
`endif
        return 0;
    endfunction

    // Transaction model: a grant opens a frame whose cycle-by-cycle outputs
    // follow from its offset since the grant.
    bit                 m_active = 0;
    int                 m_off = 0;
    int                 m_id = 0;
    int                 m_ptr = 0;
    logic [2:0]         m_sel = '0;
    logic [FRAME_W-1:0] m_tx = '0;
    logic [FRAME_W-1:0] m_rx = '0;
    logic [1:0]         h_id = '0;
    logic [FRAME_W-1:0] h_data = '0;
    logic               h_err = 1'b0;

    always @(negedge clk) begin
        logic [N_REQ-1:0] e_ready;
        logic             e_busy, e_rv, e_si;
        logic [2:0]       e_sel;
        int               w;
        e_ready = '0;
        e_busy  = 1'b0;
        e_rv    = 1'b0;
        e_si    = 1'b0;
        e_sel   = UTAP_NONE;
        if (rst_n !== 1'b1) begin
            m_active = 0;
            m_ptr    = 0;
            h_id     = '0;
            h_data   = '0;
            h_err    = 1'b0;
        end else if (!m_active) begin
            if (|req_valid) begin
                w          = pickWinner(req_valid, m_ptr);
                e_ready[w] = 1'b1;
                m_active   = 1;
                m_off      = 1;
                m_id       = w;
                m_sel      = req_sel[3*w +: 3];
                m_tx       = req_data[FRAME_W*w +: FRAME_W];
                m_rx       = '0;
                m_ptr      = (w + 1) % N_REQ;
            end
        end else begin
            e_busy = 1'b1;
            if (m_sel == UTAP_NONE) begin
                e_rv = 1'b1; h_id = 2'(m_id); h_data = '0; h_err = 1'b1; m_active = 0;
            end else if (m_off == 1) begin
                e_sel = m_sel;
            end else if (m_off <= FRAME_W + 1) begin
                e_sel = m_sel;
                e_si  = m_tx[FRAME_W - 1 - (m_off - 2)];
                m_rx  = {m_rx[FRAME_W-2:0], tap_so};
            end else begin
                e_rv = 1'b1; h_id = 2'(m_id); h_data = m_rx; h_err = 1'b0; m_active = 0;
            end
            m_off++;
        end
        checkOutput("req_ready", 32'(req_ready), 32'(e_ready));
        checkOutput("busy", 32'(busy), 32'(e_busy));
        checkOutput("tap_sel", 32'(tap_sel), 32'(e_sel));
        checkOutput("tap_si", 32'(tap_si), 32'(e_si));
        checkOutput("rsp_valid", 32'(rsp_valid), 32'(e_rv));
        checkOutput("rsp_id", 32'(rsp_id), 32'(h_id));
        checkOutput("rsp_data", 32'(rsp_data), 32'(h_data));
        checkOutput("rsp_err", 32'(rsp_err), 32'(h_err));
    end

    task automatic waitGrant(input int i, output int t0);
        t0 = -1;
        for (int k = 0; k < 200 && t0 < 0; k++) begin
            @(negedge clk);
            if (req_ready[i]) t0 = cyc;
            @(posedge clk);
            #1;
        end
        checkOutput("grant_wait", 32'(t0 >= 0), 32'd1);
    endtask

    task automatic waitResponse(input int t0, output int lat, output logic [FRAME_W-1:0] si_bits,
                                output logic [1:0] id, output logic [FRAME_W-1:0] data,
                                output logic err, output logic [2:0] sel_or);
        lat = -1; si_bits = '0; id = '0; data = '0; err = 1'b0; sel_or = '0;
        for (int k = 0; k < 60 && lat < 0; k++) begin
            @(negedge clk);
            sel_or |= tap_sel;
            if (cyc - t0 >= 2 && cyc - t0 <= FRAME_W + 1) si_bits = {si_bits[FRAME_W-2:0], tap_si};
            if (rsp_valid) begin
                lat = cyc - t0; id = rsp_id; data = rsp_data; err = rsp_err;
            end
            @(posedge clk);
            #1;
        end
        checkOutput("rsp_wait", 32'(lat >= 0), 32'd1);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_ready"}, 32'(req_ready), 32'd0);
        checkOutput({tag, "_tap_sel"}, 32'(tap_sel), 32'd0);
        checkOutput({tag, "_tap_si"}, 32'(tap_si), 32'd0);
        checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        checkOutput({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
        checkOutput({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
        checkOutput({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int                 t0, lat, rsp_cnt, n_exp;
        logic [FRAME_W-1:0] si_bits, data;
        logic [1:0]         id;
        logic               err, r0_dropped, done;
        logic [2:0]         sel_or;
        int                 glog[$];
        int                 rlog[$];
        int                 exp_g[$];

        rst_n = 1'b0;
        #23;
        checkAllZero("reset");
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] single request, loopback tap");
        tap_random = 1'b0;
        applyStimulus(0, 1'b1, UTAP_PC, 16'hA5C3);
        waitGrant(0, t0);
        applyStimulus(0, 1'b0, UTAP_NONE, '0);
        waitResponse(t0, lat, si_bits, id, data, err, sel_or);
        checkOutput("single_latency", 32'(lat), 32'd18);
        checkOutput("single_tap_si", 32'(si_bits), 32'h0000A5C3);
        checkOutput("single_rsp_data", 32'(data), 32'h000052E1);
        checkOutput("single_rsp_id", 32'(id), 32'd0);
        checkOutput("single_rsp_err", 32'(err), 32'd0);

        $display("[TB] sel==0 request on requester 1");
        applyStimulus(1, 1'b1, UTAP_NONE, 16'hFFFF);
        waitGrant(1, t0);
        applyStimulus(1, 1'b0, UTAP_NONE, '0);
        waitResponse(t0, lat, si_bits, id, data, err, sel_or);
        checkOutput("none_latency", 32'(lat), 32'd1);
        checkOutput("none_rsp_err", 32'(err), 32'd1);
        checkOutput("none_rsp_data", 32'(data), 32'd0);
        checkOutput("none_rsp_id", 32'(id), 32'd1);
        checkOutput("none_tap_sel", 32'(sel_or), 32'd0);

        $display("[TB] contention between requesters 0 and 1");
`ifdef UTAP_SCHED_RR_EN
        exp_g = '{0, 1, 0, 1, 0, 1};
`else
        exp_g = '{0, 0, 0, 0, 1};
`endif
        applyStimulus(0, 1'b1, UTAP_PC, 16'($urandom));
        applyStimulus(1, 1'b1, UTAP_PC, 16'($urandom));
        r0_dropped = 1'b0;
        done = 1'b0;
        sel_or = '0;
        for (int k = 0; k < 400 && !(done && rlog.size() == glog.size()); k++) begin
            @(negedge clk);
            acc = req_ready;
            if (|acc) begin
                glog.push_back(acc[1] ? 1 : 0);
                sel_or |= tap_sel;
            end
            if (rsp_valid) rlog.push_back(int'(rsp_id));
            @(posedge clk);
            #1;
            if (acc[0]) begin
                r0_dropped = (glog.size() >= 4);
                applyStimulus(0, !r0_dropped, UTAP_PC, 16'($urandom));
            end
            if (acc[1]) begin
                done = r0_dropped;
                applyStimulus(1, !done, UTAP_PC, 16'($urandom));
            end
        end
        n_exp = exp_g.size();
        checkOutput("cont_grant_count", 32'(glog.size()), 32'(n_exp));
        checkOutput("cont_rsp_count", 32'(rlog.size()), 32'(n_exp));
        for (int k = 0; k < n_exp && k < glog.size(); k++)
            checkOutput($sformatf("cont_grant%0d", k), 32'(glog[k]), 32'(exp_g[k]));
        for (int k = 0; k < n_exp && k < rlog.size(); k++)
            checkOutput($sformatf("cont_rsp_id%0d", k), 32'(rlog[k]), 32'(exp_g[k]));
        checkOutput("cont_idle_tap_sel", 32'(sel_or), 32'd0);

        $display("[TB] reset during bit 7 of the shift phase");
        applyStimulus(0, 1'b1, UTAP_PC, 16'h1234);
        waitGrant(0, t0);
        applyStimulus(0, 1'b0, UTAP_NONE, '0);
        repeat (9) @(negedge clk);
        checkOutput("abort_pre_busy", 32'(busy), 32'd1);
        checkOutput("abort_pre_tap_sel", 32'(tap_sel), 32'(UTAP_PC));
        #1;
        rst_n = 1'b0;
        #1;
        checkAllZero("abort");
        rsp_cnt = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (rsp_valid) rsp_cnt++;
            @(posedge clk);
            #2;
            if (k == 2) rst_n = 1'b1;
        end
        checkOutput("abort_no_rsp", 32'(rsp_cnt), 32'd0);
        applyStimulus(0, 1'b1, UTAP_PC, 16'h0F0F);
        waitGrant(0, t0);
        applyStimulus(0, 1'b0, UTAP_NONE, '0);
        waitResponse(t0, lat, si_bits, id, data, err, sel_or);
        checkOutput("after_reset_latency", 32'(lat), 32'd18);
        checkOutput("after_reset_tap_si", 32'(si_bits), 32'h00000F0F);
        checkOutput("after_reset_rsp_id", 32'(id), 32'd0);

        $display("[TB] randomized traffic");
        tap_random = 1'b1;
        rsp_cnt = 0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            acc = req_ready;
            if (rsp_valid) rsp_cnt++;
            @(posedge clk);
            #1;
            for (int i = 0; i < N_REQ; i++) begin
                if (acc[i] || !req_valid[i]) begin
                    if ($urandom_range(0, 3) == 0)
                        applyStimulus(i, 1'b1,
                                      ($urandom_range(0, 3) == 0) ? UTAP_NONE : 3'($urandom_range(1, 7)),
                                      16'($urandom));
                    else if (acc[i])
                        applyStimulus(i, 1'b0, UTAP_NONE, '0);
                end
            end
        end
        req_valid = '0;
        repeat (25) @(posedge clk);
        #1;
        checkOutput("rand_rsp_seen", 32'(rsp_cnt > 20), 32'd1);
        checkOutput("final_idle", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/utap_sched.md
UTAP_SCHED -- requirements
Module: utap_sched

Interface
REQ-001 SHALL have parameter N_REQ, default 2: number of requesters, range 2..4.
REQ-002 SHALL have parameter FRAME_W, default 16: bits per tap frame.
REQ-003 SHALL have port clk  in  1  single clock; all logic on posedge.
REQ-004 SHALL have port rst_n  in  1  reset; asynchronous, active-low.
REQ-005 SHALL have port req_valid  in  N_REQ  per-requester frame request.
REQ-006 SHALL have port req_sel  in  3*N_REQ  per-requester tap domain select.
REQ-007 SHALL have port req_data  in  FRAME_W*N_REQ  per-requester outbound frame.
REQ-008 SHALL have port req_ready  out  N_REQ  one-hot accept pulse.
REQ-009 SHALL have port rsp_valid  out  1  one-cycle response pulse.
REQ-010 SHALL have port rsp_id  out  2  requester index of the response.
REQ-011 SHALL have port rsp_data  out  FRAME_W  captured inbound frame.
REQ-012 SHALL have port rsp_err  out  1  request had sel==0 and was not shifted.
REQ-013 SHALL have port tap_sel  out  3  select lines to the debug tap.
REQ-014 SHALL have port tap_si  out  1  serial bit to the tap.
REQ-015 SHALL have port tap_so  in  1  serial bit from the tap.
REQ-016 SHALL have port busy  out  1  high whenever state != IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, SELECT, SHIFT, DONE.
REQ-018 IDLE with any req_valid: grant one requester, assert its req_ready combinationally that cycle, latch sel/data/index, go SELECT; otherwise stay.
REQ-019 Grant with sel==0 SHALL go directly to DONE with rsp_err=1, rsp_data=0; tap pins untouched.
REQ-020 SELECT SHALL drive tap_sel=latched sel for exactly 1 cycle, tap_si=0; covers the tap's 1-cycle select register.
REQ-021 SHALL hold tap_sel through SHIFT for exactly FRAME_W cycles; tap_si = tx frame MSB first; tap_so sampled each cycle into rx LSB, shifting left.
REQ-022 Bit counter SHALL be $clog2(FRAME_W+1) bits and SHALL leave SHIFT when it reaches FRAME_W-1; it SHALL not wrap mid-frame.
REQ-023 DONE SHALL assert rsp_valid for 1 cycle with rsp_id/rsp_data/rsp_err, drive tap_sel=0, then go IDLE.
REQ-024 Latency from req_ready to rsp_valid SHALL be FRAME_W+2 cycles (18 at default); sel==0 path SHALL take 1 cycle.
REQ-025 req_ready SHALL be 0 in all states except IDLE; requesters hold req_valid/sel/data until accepted.
REQ-026 Back-to-back requests SHALL have at least one IDLE cycle between frames (tap_sel=0), so the tap clears its counter.
REQ-027 rsp_data/rsp_id/rsp_err SHALL hold their last values outside DONE; only rsp_valid qualifies them.

Reset
REQ-028 rst_n low SHALL asynchronously force IDLE, tap_sel=0, tap_si=0, req_ready=0, rsp_valid=0, rsp_err=0, rsp_id=0, rsp_data=0, busy=0, counter=0, and reset the arbitration pointer to requester 0.
REQ-029 Reset mid-frame SHALL abort with no rsp_valid; the aborted requester is not re-served automatically.

Configuration
REQ-030 With UTAP_SCHED_RR_EN defined, arbitration SHALL be round-robin: search starts at last-granted index+1, wrapping at N_REQ.
REQ-031 Without UTAP_SCHED_RR_EN, arbitration SHALL be fixed priority, lowest index highest; no pointer register is built.

Structure
REQ-032 Package utap_pkg SHALL hold the domain constants (UTAP_NONE=3'h0, UTAP_PC=3'h1), the FRAME_W default and the state enum typedef.
REQ-033 Arbitration SHALL be a sub-module utap_rr_arb (req vector, advance strobe -> one-hot grant), honouring UTAP_SCHED_RR_EN.

Verification
REQ-034 Single request: req0 sel=1, data=16'hA5C3, tap_so tied to tap_si through 1-cycle delay -> tap_si MSB-first 1010010111000011, rsp_valid 18 cycles after ready, rsp_id=0.
REQ-035 Contention, RR enabled: req0 and req1 valid continuously -> grants 0,1,0,1; each rsp_id matches grant order; an IDLE cycle with tap_sel=0 between frames.
REQ-036 Contention, RR disabled: same stimulus -> req0 granted every frame; req1 starves until req0 drops.
REQ-037 sel==0 request: req1 sel=0 -> rsp_valid next cycle, rsp_err=1, rsp_data=0, tap_sel stays 0.
REQ-038 rst_n low at bit 7 of SHIFT -> all outputs zero immediately (async); no rsp_valid; after release, a new req0 completes normally.
